// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams, locked per packet.
// Grant 1 cycle after request, tx_start 1 cycle after handshake; req_ready only to the owner in LOAD with tx idle.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 1024,
  parameter int BUSY_TIMEOUT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 active
);

  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam int BUSY_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} state_t;

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gidx;
  logic [7:0]          burst_cnt;
  logic [STALL_W-1:0]  stall_cnt;
  logic [BUSY_W-1:0]   busy_cnt;
  logic                last_q;

  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [7:0]          sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic [PTR_W-1:0]    next_ptr;
  logic                pkt_end;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PTR_W:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (!pick_vld && req_valid[sum[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    pick_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == PTR_W'(i)) begin
        sel_data  = req_data[8*i +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
      pick_oh[i] = (pick_idx == PTR_W'(i));
    end
  end

  assign next_ptr  = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign pkt_end   = last_q || (burst_cnt == 8'(MAX_BURST));
  assign req_ready = (state == LOAD && !tx_busy) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      active    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      rr_ptr    <= '0;
      gidx      <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
      busy_cnt  <= '0;
      last_q    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick_oh;
            gidx      <= pick_idx;
            active    <= 1'b1;
            burst_cnt <= '0;
            stall_cnt <= '0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (sel_valid && !tx_busy) begin
            tx_data   <= sel_data;
            last_q    <= sel_last;
            if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
            stall_cnt <= '0;
            tx_start  <= 1'b1;
            state     <= START;
          end else if (!sel_valid) begin
            // Owner went quiet mid-packet: give the line to someone else.
            if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
              grant  <= '0;
              active <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
        end
        START: begin
          busy_cnt <= '0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (busy_cnt == BUSY_W'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never acknowledged; treat the byte as sent.
            if (pkt_end) begin
              grant  <= '0;
              active <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state <= LOAD;
            end
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (pkt_end) begin
              grant  <= '0;
              active <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART-TX busy model and a tx_start logger.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int MAX_BURST     = 16;
  localparam int STALL_TIMEOUT = 1024;
  localparam int BUSY_TIMEOUT  = 4;
  localparam int FRAME         = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        active;

  logic        tx_dead = 1'b0;
  int          frame_left = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          log_n = 0;
  int          bad_ready = 0;
  int          proto_err = 0;
  logic        prev_start = 1'b0;
  logic        drop0 = 1'b0;
  logic [7:0]  log_dat [0:255];
  logic [3:0]  log_gnt [0:255];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST),
    .STALL_TIMEOUT(STALL_TIMEOUT), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .active(active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for FRAME cycles after each start, unless dead.
  always @(posedge clk) begin
    if (tx_start && !tx_dead) frame_left <= FRAME;
    else if (frame_left != 0) frame_left <= frame_left - 1;
  end
  assign tx_busy = (frame_left != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      if (log_n < 256) begin
        log_dat[log_n[7:0]] <= tx_data;
        log_gnt[log_n[7:0]] <= grant;
      end
      log_n <= log_n + 1;
    end
    if ((req_ready & ~grant) != 4'b0000) bad_ready <= bad_ready + 1;
    if (tx_start && (tx_busy || prev_start)) proto_err <= proto_err + 1;
    prev_start <= tx_start;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and return right after the handshake edge (DUT then in START).
  task automatic send_byte(input int idx, input logic [7:0] d, input logic l, input string tag);
    int n = 0;
    req_valid[idx] = 1'b1;
    req_data[idx*8 +: 8] = d;
    req_last[idx] = l;
    while (!req_ready[idx] && n < 100) begin
      cyc();
      n++;
      if (drop0 && idx != 0 && req_ready[0]) begin
        cyc();
        req_valid[0] = 1'b0;
        drop0 = 1'b0;
      end
    end
    chk(tag, 32'(req_ready[idx]), 32'd1);
    cyc();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((active || tx_busy) && n < 400) begin
      cyc();
      n++;
    end
    chk(tag, 32'(active), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    // Reset values
    cyc(); cyc(); cyc();
    chk("rst_grant",  32'(grant),      32'd0);
    chk("rst_active", 32'(active),     32'd0);
    chk("rst_ready",  32'(req_ready),  32'd0);
    chk("rst_start",  32'(tx_start),   32'd0);
    chk("rst_data",   32'(tx_data),    32'd0);
    chk("rst_ptr",    32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;

    // Single byte from requester 0
    req_valid[0] = 1'b1; req_data[7:0] = 8'h41; req_last[0] = 1'b1;
    cyc();
    chk("sb_grant",  32'(grant),     32'h1);
    chk("sb_active", 32'(active),    32'd1);
    chk("sb_ready",  32'(req_ready), 32'h1);
    chk("sb_nostart", 32'(tx_start), 32'd0);
    cyc();
    chk("sb_start", 32'(tx_start),  32'd1);
    chk("sb_data",  32'(tx_data),   32'h41);
    chk("sb_ready_off", 32'(req_ready), 32'd0);
    req_valid[0] = 1'b0;
    cyc();
    chk("sb_pulse", 32'(tx_start), 32'd0);
    n = 0;
    while (tx_busy && n < 50) begin cyc(); n++; end
    chk("sb_hold", 32'(grant), 32'h1);
    cyc();
    chk("sb_rel_grant",  32'(grant),      32'd0);
    chk("sb_rel_active", 32'(active),     32'd0);
    chk("sb_rel_ptr",    32'(dut.rr_ptr), 32'd1);

    // Round-robin with all four requesters always valid
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'hA3A2A1A0;
    base = log_n;
    n = 0;
    while (log_n < base + 5 && n < 300) begin cyc(); n++; end
    req_valid = 4'h0;
    wait_idle("rr_idle");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 32'(log_gnt[base+k]), 32'(1) << (k % 4));
      chk($sformatf("rr_data%0d", k),  32'(log_dat[base+k]), 32'hA0 + 32'(k % 4));
    end
    chk("rr_bad_ready", 32'(bad_ready), 32'd0);

    // Packet lock: requester 1 sends HELLO while requester 2 waits
    req_last = 4'h0;
    req_valid[2] = 1'b1; req_data[23:16] = 8'h32; req_last[2] = 1'b1;
    base = log_n;
    send_byte(1, 8'h48, 1'b0, "pl_H");
    send_byte(1, 8'h45, 1'b0, "pl_E");
    send_byte(1, 8'h4C, 1'b0, "pl_L1");
    send_byte(1, 8'h4C, 1'b0, "pl_L2");
    send_byte(1, 8'h4F, 1'b1, "pl_O");
    req_valid[1] = 1'b0;
    n = 0;
    while (log_n < base + 6 && n < 200) begin cyc(); n++; end
    req_valid[2] = 1'b0;
    wait_idle("pl_idle");
    begin
      logic [39:0] hello;
      hello = 40'h48454C4C4F;
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("pl_data%0d", k),  32'(log_dat[base+k]), 32'(hello[8*(4-k) +: 8]));
        chk($sformatf("pl_grant%0d", k), 32'(log_gnt[base+k]), 32'h2);
      end
    end
    chk("pl_next_grant", 32'(log_gnt[base+5]), 32'h4);
    chk("pl_next_data",  32'(log_dat[base+5]), 32'h32);
    chk("pl_ptr",        32'(dut.rr_ptr),      32'd3);

    // Burst limit on requester 3, requester 0 served in between, then stall timeout
    req_valid[0] = 1'b1; req_data[7:0] = 8'hB0; req_last[0] = 1'b1; drop0 = 1'b1;
    base = log_n;
    for (int k = 1; k <= 20; k++) send_byte(3, 8'(k), 1'b0, $sformatf("bl_b%0d", k));
    req_valid[3] = 1'b0;
    n = 0;
    while (!req_ready[3] && n < 100) begin cyc(); n++; end
    n = 0;
    while (grant == 4'b1000 && n < 1100) begin n++; cyc(); end
    chk("stall_cycles", 32'(n),          32'(STALL_TIMEOUT));
    chk("stall_grant",  32'(grant),      32'd0);
    chk("stall_ptr",    32'(dut.rr_ptr), 32'd0);
    chk("bl_count",     32'(log_n - base), 32'd21);
    for (int j = 0; j < 21; j++) begin
      if (j == 16) begin
        chk("bl_other_grant", 32'(log_gnt[base+j]), 32'h1);
        chk("bl_other_data",  32'(log_dat[base+j]), 32'hB0);
      end else begin
        chk($sformatf("bl_grant%0d", j), 32'(log_gnt[base+j]), 32'h8);
        chk($sformatf("bl_data%0d", j),  32'(log_dat[base+j]), (j < 16) ? 32'(j + 1) : 32'(j));
      end
    end

    // Busy timeout: transmitter never raises tx_busy
    tx_dead = 1'b1;
    send_byte(1, 8'hA5, 1'b0, "bt_b0");
    chk("bt_start0", 32'(tx_start), 32'd1);
    chk("bt_data0",  32'(tx_data),  32'hA5);
    n = 0;
    cyc();
    while (!req_ready[1] && n < 50) begin n++; cyc(); end
    chk("bt_wait", 32'(n), 32'(BUSY_TIMEOUT));
    send_byte(1, 8'h5A, 1'b1, "bt_b1");
    chk("bt_data1", 32'(tx_data), 32'h5A);
    req_valid[1] = 1'b0;
    wait_idle("bt_idle");
    chk("bt_ptr", 32'(dut.rr_ptr), 32'd2);
    tx_dead = 1'b0;

    // Reset while waiting for the frame to finish
    send_byte(2, 8'hC3, 1'b1, "mr_b0");
    req_valid[2] = 1'b0;
    cyc(); cyc();
    chk("mr_pre_grant", 32'(grant), 32'h4);
    rst = 1'b1;
    cyc();
    chk("mr_grant",  32'(grant),      32'd0);
    chk("mr_active", 32'(active),     32'd0);
    chk("mr_ready",  32'(req_ready),  32'd0);
    chk("mr_start",  32'(tx_start),   32'd0);
    chk("mr_data",   32'(tx_data),    32'd0);
    chk("mr_ptr",    32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;
    wait_idle("mr_idle");

    chk("bad_ready_total", 32'(bad_ready), 32'd0);
    chk("proto_err_total", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
